// File: rtl/burst_ram_responder_if.sv
// Burst RAM command bus between the ramio controller (master) and a
// responder such as burst_ram_responder (slave).
interface burst_ram_responder_if #(
  parameter int AddressBitWidth = 21
);
  logic                       init_calib;
  logic                       cmd;
  logic                       cmd_en;
  logic [AddressBitWidth-1:0] addr;
  logic [63:0]                wr_data;
  logic [7:0]                 data_mask;
  logic [63:0]                rd_data;
  logic                       rd_data_valid;
  logic                       busy;
  logic                       cmd_overrun;

  modport master (
    input  init_calib, rd_data, rd_data_valid, busy, cmd_overrun,
    output cmd, cmd_en, addr, wr_data, data_mask
  );

  modport slave (
    output init_calib, rd_data, rd_data_valid, busy, cmd_overrun,
    input  cmd, cmd_en, addr, wr_data, data_mask
  );
endinterface

// File: rtl/burst_ram_responder.sv
// Block-RAM backed responder for the burst RAM command bus: calibration delay,
// 4-beat 64-bit write/read bursts with byte masks and a fixed read latency.
module burst_ram_responder #(
  parameter int AddressBitWidth       = 21,
  parameter int DepthBitWidth         = 12,
  parameter int BurstDataCount        = 4,
  parameter int CyclesBeforeDataValid = 6,
  parameter int CyclesBeforeInitiated = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  burst_ram_responder_if.slave br
);

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_WRITE      = 3'd2,
    ST_READ_WAIT  = 3'd3,
    ST_READ_BURST = 3'd4
  } state_e;

  localparam int Depth = 1 << DepthBitWidth;
  localparam int CntW  = 16;
  localparam logic [CntW-1:0] CalibLoad = CntW'(CyclesBeforeInitiated - 1);
  // READ_WAIT lasts L-2 cycles so the first word address goes out at T0+L-1.
  localparam logic [CntW-1:0] WaitLoad  = CntW'(CyclesBeforeDataValid - 3);
  localparam logic [2:0] LastBeat  = 3'(BurstDataCount - 1);
  localparam logic [2:0] DrainBeat = 3'(BurstDataCount);

  state_e                   state_q;
  logic [CntW-1:0]          cnt_q;
  logic [2:0]               beat_q;
  logic [DepthBitWidth-1:0] base_q;
  logic                     init_calib_q;
  logic                     overrun_q;
  logic [63:0]              rd_data_q;
  logic                     rd_valid_q;
  logic [63:0]              mem_q [0:Depth-1];

  logic [DepthBitWidth-1:0] cmd_base_s;
  logic [DepthBitWidth-1:0] wr_addr_s;
  logic [DepthBitWidth-1:0] rd_addr_s;
  logic                     wr_en_s;
  logic                     rd_en_s;
  logic                     unused_addr_s;

  assign cmd_base_s    = br.addr[DepthBitWidth+2:3];
  assign unused_addr_s = ^{br.addr[AddressBitWidth-1:DepthBitWidth+3], br.addr[2:0]};

  // Store port control: beat 0 of a write comes straight off the bus.
  always_comb begin
    wr_en_s   = 1'b0;
    rd_en_s   = 1'b0;
    wr_addr_s = base_q + DepthBitWidth'(beat_q);
    rd_addr_s = base_q + DepthBitWidth'(beat_q);
    if (rst_i) begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end else if (state_q == ST_IDLE && br.cmd_en && br.cmd) begin
      wr_en_s   = 1'b1;
      wr_addr_s = cmd_base_s;
    end else if (state_q == ST_WRITE) begin
      wr_en_s = 1'b1;
    end else if (state_q == ST_READ_BURST && beat_q != DrainBeat) begin
      rd_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end
  end

  // Command FSM with calibration, latency and beat counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_INIT;
      cnt_q        <= CalibLoad;
      beat_q       <= 3'd0;
      base_q       <= {DepthBitWidth{1'b0}};
      init_calib_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (br.cmd_en && state_q != ST_IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_INIT: begin
          if (cnt_q == {CntW{1'b0}}) begin
            state_q      <= ST_IDLE;
            init_calib_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_IDLE: begin
          if (br.cmd_en) begin
            base_q <= cmd_base_s;
            if (br.cmd) begin
              state_q <= ST_WRITE;
              beat_q  <= 3'd1;
            end else if (CyclesBeforeDataValid == 2) begin
              state_q <= ST_READ_BURST;
              beat_q  <= 3'd0;
            end else begin
              state_q <= ST_READ_WAIT;
              beat_q  <= 3'd0;
              cnt_q   <= WaitLoad;
            end
          end
        end
        ST_WRITE: begin
          if (beat_q == LastBeat) begin
            state_q <= ST_IDLE;
          end else begin
            beat_q <= beat_q + 3'd1;
          end
        end
        ST_READ_WAIT: begin
          if (cnt_q == {CntW{1'b0}}) begin
            state_q <= ST_READ_BURST;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_READ_BURST: begin
          // One extra cycle after the last issue keeps busy high while beat 3 is shown.
          if (beat_q == DrainBeat) begin
            state_q <= ST_IDLE;
          end else begin
            beat_q <= beat_q + 3'd1;
          end
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= CalibLoad;
        end
      endcase
    end
  end

  // Byte-masked write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int b = 0; b < 8; b++) begin
        if (!br.data_mask[b]) begin
          mem_q[wr_addr_s][8*b +: 8] <= br.wr_data[8*b +: 8];
        end
      end
    end
  end

  // Registered read port; data holds between bursts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q  <= 64'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_s;
      if (rd_en_s) begin
        rd_data_q <= mem_q[rd_addr_s];
      end
    end
  end

  assign br.init_calib    = init_calib_q;
  assign br.busy          = (state_q != ST_IDLE);
  assign br.cmd_overrun   = overrun_q;
  assign br.rd_data       = rd_data_q;
  assign br.rd_data_valid = rd_valid_q;

endmodule
